ssm_demux: RTL
==============

# ssm_demux

Substream demultiplexer feeding the per-SSM funnel shifters of the VDC-M decoder.
- Accepts the muxed 128-bit word stream from the rate buffer and pre-loads every substream FIFO with a fixed number of words.
- After pre-load, each pop by SSM k triggers exactly one refill. Refills are steered to SSM k in request order, so the stream order matches the encoder mux order.
- Sits between the input rate buffer and the `bitparse_ssm*` funnel shifters. Each FIFO is show-ahead, so `rd_data` is valid in the same cycle the consumer samples it with `codec_data_rd_en`.

## Interface
Parameters:
- `NSSM`, 4: number of substreams.
- `DW`, 128: mux word width.
- `DEPTH`, 4: words per substream FIFO (power of 2).
- `INIT_WORDS`, 2: pre-load words per substream. Legal range 1..`DEPTH`.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse; begin a slice (flush and pre-load).
- `in_data` in `DW`: mux word from the rate buffer.
- `in_valid` in 1: `in_data` valid.
- `in_ready` out 1: word accepted when `in_valid & in_ready`.
- `rd_en` in `NSSM`: bit k = pop request from SSM k (its `codec_data_rd_en`).
- `rd_data` out `NSSM*DW`: slice k = head of FIFO k; all-zero when FIFO k is empty.
- `empty` out `NSSM`: FIFO k empty.
- `init_done` out 1: pre-load complete. Gates `start_dec` downstream.
- `err` out 1: sticky error flag. Exists only with the macro; otherwise tied 0.

## Operation
State machine states: IDLE, INIT, RUN.

- **Reset:** state IDLE; all FIFOs and the request queue empty; `in_ready`=0, `init_done`=0, `err`=0, `rd_data`=0, `empty`=all ones.
- **`start` pulse, any state:**
  - Flushes all FIFO pointers and the request queue.
  - Clears `init_done`.
  - Next state INIT with `ssm_idx`=0, `word_cnt`=0.
  - `start` takes priority over any same-cycle accept or pop.
- **INIT:**
  - `in_ready`=1.
  - Each accepted word goes to FIFO `ssm_idx`, then `word_cnt` increments.
  - When `word_cnt` reaches `INIT_WORDS-1`: `word_cnt` returns to 0 and `ssm_idx` increments.
  - After the last word for SSM `NSSM-1`: next state RUN and `init_done`=1.
  - `rd_en` is ignored during INIT. No pop occurs and no request is queued.
- **RUN, pops:**
  - A pop of FIFO k occurs when `rd_en[k]` is set and `empty[k]` is clear.
  - Each pop pushes id k into the request queue (depth `NSSM*DEPTH`, id width clog2(`NSSM`)).
  - Several pops in the same cycle push their ids in ascending k. The queue accepts up to `NSSM` pushes per cycle.
- **RUN, service:**
  - `in_ready` = queue not empty AND FIFO[head] not full.
  - On accept: the word is written to FIFO[head] and the head id is popped.
  - At most one word is accepted per cycle.
- **Same-cycle interactions:**
  - A pop and a write on the same FIFO in the same cycle are legal; occupancy is unchanged.
  - A queue push and a queue pop in the same cycle are legal.
- **Occupancy invariant in RUN:** occupancy k + outstanding requests for k = `INIT_WORDS`. Therefore the queue never overflows and no FIFO exceeds `INIT_WORDS`.
- **Pop on empty:** ignored; `rd_data` slice stays 0.
- **Widths:**
  - FIFO pointers are clog2(`DEPTH`)+1 bits and wrap.
  - Queue pointers are clog2(`NSSM*DEPTH`)+1 bits and wrap.

## Timing
- A word accepted at cycle t is visible on `rd_data` slice k and clears `empty[k]` at t+1. There is no same-cycle bypass.
- A pop at cycle t advances the head at t+1. `rd_data` is combinational from storage and the read pointer.
- A pop at t can refill at t+1 at the earliest: the queue is pushed at t and the new entry is visible at t+1.
- `init_done` rises in the cycle after the final pre-load accept.
- Total pre-load takes `NSSM*INIT_WORDS` accepts. With `in_valid` held high it spans 8 cycles at the defaults.
- `start` at t: flush at t+1 edge; the first INIT accept is possible at t+1.

## Configuration
Macro `SSM_DEMUX_ERR_CHK_EN`.
- **Defined:** `err` sets and stays set until the next `start` or reset on any of:
  - `rd_en[k]` while `empty[k]` (underflow);
  - `rd_en` nonzero during INIT;
  - queue push while the queue is full.
- **Undefined:** this checking logic is absent and `err` is constant 0.

## Test plan
- **Reset then pre-load:** `start`, then words W0..W7 with `in_valid` held high.
  - FIFO0 = {W0,W1}, FIFO1 = {W2,W3}, FIFO2 = {W4,W5}, FIFO3 = {W6,W7}.
  - `init_done`=1 at cycle 9; `rd_data` slice 2 = W4.
- **Single refill:** pop SSM1 once, then supply W8.
  - SSM1 head = W3, then W3,W8 in order.
  - `in_ready` drops after the accept.
- **Simultaneous pops:** `rd_en`=4'b1010, then supply W8,W9.
  - W8 goes to SSM1 and W9 to SSM3 (ascending order).
- **Back-pressure:** pop SSM0 twice with `in_valid`=0 for 5 cycles.
  - `empty[0]`=1 and `rd_data` slice 0 = 0.
  - `in_ready`=1 throughout.
  - Refills W8,W9 then land in FIFO0.
- **Restart mid-RUN:** `start` with 3 requests outstanding.
  - Queue and FIFOs are cleared and `init_done`=0.
  - The next 8 words pre-load again from SSM0.
- **Error check (macro defined):** `rd_en[2]` while `empty[2]`.
  - `err`=1 next cycle and held until `start`.

Source files
------------

// File: rtl/ssm_demux_if.sv
// ============================================================================
// Module  : ssm_demux_if
// Brief   : Word-stream and per-substream read bundle for ssm_demux.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ssm_demux_if #(
    parameter int NSSM = 4,
    parameter int DW   = 128
);
    logic                 start;
    logic [DW-1:0]        in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [NSSM-1:0]      rd_en;
    logic [NSSM*DW-1:0]   rd_data;
    logic [NSSM-1:0]      empty;
    logic                 init_done;
    logic                 err;

    modport master (
        output start, in_data, in_valid, rd_en,
        input  in_ready, rd_data, empty, init_done, err
    );

    modport slave (
        input  start, in_data, in_valid, rd_en,
        output in_ready, rd_data, empty, init_done, err
    );
endinterface

`default_nettype wire

// File: rtl/ssm_demux.sv
// ============================================================================
// Module  : ssm_demux
// Brief   : Substream demux: pre-loads NSSM show-ahead FIFOs, then refills
//           each FIFO in pop-request order. Optional macro: SSM_DEMUX_ERR_CHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ssm_demux #(
    parameter int NSSM       = 4,
    parameter int DW         = 128,
    parameter int DEPTH      = 4,
    parameter int INIT_WORDS = 2
) (
    input  wire logic   clk,
    input  wire logic   rstn,
    ssm_demux_if.slave  bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int QD  = NSSM * DEPTH;
    localparam int QAW = $clog2(QD);
    localparam int IDW = $clog2(NSSM);
    localparam int CW  = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]      state, state_nxt;
    logic [IDW-1:0]  ssm_idx;
    logic [CW-1:0]   word_cnt;

    logic [DW-1:0]   mem [NSSM][DEPTH];
    logic [AW:0]     wr_ptr [NSSM];
    logic [AW:0]     rd_ptr [NSSM];
    logic [NSSM-1:0] fifo_empty, fifo_full, pop, wr;

    logic [IDW-1:0]  qmem [QD];
    logic [QAW:0]    q_wr, q_rd, q_cnt, push_cnt;
    logic [QAW-1:0]  push_pos [NSSM];
    logic [IDW-1:0]  q_head;
    logic            q_empty;

    logic            in_init, in_run, accept, last_word, q_pop;
    logic [IDW-1:0]  wr_sel;

    assign in_init   = (state == S_INIT);
    assign in_run    = (state == S_RUN);
    assign accept    = bus.in_valid & bus.in_ready & ~bus.start;
    assign q_pop     = accept & in_run;
    assign last_word = in_init & accept & (ssm_idx == IDW'(NSSM - 1))
                     & (word_cnt == CW'(INIT_WORDS - 1));
    assign q_cnt     = q_wr - q_rd;
    assign q_empty   = (q_cnt == '0);
    assign q_head    = qmem[q_rd[QAW-1:0]];
    assign wr_sel    = in_init ? ssm_idx : q_head;

    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < NSSM; k++) begin
            fifo_empty[k] = (wr_ptr[k] == rd_ptr[k]);
            fifo_full[k]  = (wr_ptr[k][AW] != rd_ptr[k][AW]) &&
                            (wr_ptr[k][AW-1:0] == rd_ptr[k][AW-1:0]);
            pop[k] = in_run & bus.rd_en[k] & ~fifo_empty[k] & ~bus.start;
            wr[k]  = accept & (wr_sel == IDW'(k));
            if (!fifo_empty[k])
                bus.rd_data[k*DW +: DW] = mem[k][rd_ptr[k][AW-1:0]];
        end
    end

    assign bus.empty = fifo_empty;

    // Same-cycle pops land in the request queue in ascending SSM order.
    always_comb begin
        push_cnt = '0;
        for (int k = 0; k < NSSM; k++) begin
            push_pos[k] = q_wr[QAW-1:0] + push_cnt[QAW-1:0];
            if (pop[k])
                push_cnt = push_cnt + (QAW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NSSM; k++) begin
            if (wr[k])
                mem[k][wr_ptr[k][AW-1:0]] <= bus.in_data;
            if (pop[k])
                qmem[push_pos[k]] <= IDW'(k);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_wr <= '0;
            q_rd <= '0;
            for (int k = 0; k < NSSM; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else if (bus.start) begin
            q_wr <= '0;
            q_rd <= '0;
            for (int k = 0; k < NSSM; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
            end
        end else begin
            q_wr <= q_wr + push_cnt;
            if (q_pop)
                q_rd <= q_rd + (QAW+1)'(1);
            for (int k = 0; k < NSSM; k++) begin
                if (wr[k])
                    wr_ptr[k] <= wr_ptr[k] + (AW+1)'(1);
                if (pop[k])
                    rd_ptr[k] <= rd_ptr[k] + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ssm_idx  <= '0;
            word_cnt <= '0;
        end else if (bus.start) begin
            ssm_idx  <= '0;
            word_cnt <= '0;
        end else if (in_init && accept) begin
            if (word_cnt == CW'(INIT_WORDS - 1)) begin
                word_cnt <= '0;
                ssm_idx  <= ssm_idx + IDW'(1);
            end else begin
                word_cnt <= word_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.start)
            state_nxt = S_INIT;
        else if (in_init && last_word)
            state_nxt = S_RUN;
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.init_done = 1'b0;
        case (state)
            S_INIT:  bus.in_ready = 1'b1;
            S_RUN: begin
                bus.in_ready  = ~q_empty & ~fifo_full[q_head];
                bus.init_done = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef SSM_DEMUX_ERR_CHK_EN
    logic err_q;
    logic q_full;

    assign q_full = (q_cnt == (QAW+1)'(QD));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_q <= 1'b0;
        else if (bus.start)
            err_q <= 1'b0;
        else if ((|(bus.rd_en & fifo_empty)) || (in_init && (|bus.rd_en)) ||
                 (q_full && (|pop)))
            err_q <= 1'b1;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

`default_nettype wire
